pool_col_streamer: RTL and testbench



---
 rtl/cnn_pkg.sv | 30 +++
 rtl/fp16_max2.sv | 12 +
 rtl/pool_col_streamer.sv | 172 +++++++++++++++++
 tb/tb_pool_col_streamer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and fp16 ordering helpers for the CNN pooling datapath.
package cnn_pkg;

   localparam int FP16_WIDTH = 16;

   typedef enum logic [1:0] {
      HOLDOFF = 2'd0,
      EVEN    = 2'd1,
      ODD     = 2'd2
   } pool_state_e;

   // Monotonic unsigned key: larger key means larger fp16 value (NaNs ordered by bit pattern).
   function automatic logic [FP16_WIDTH-1:0] fp16_key(input logic [FP16_WIDTH-1:0] x);
      return x[FP16_WIDTH-1] ? ~x : (x ^ {1'b1, {(FP16_WIDTH-1){1'b0}}});
   endfunction

   function automatic logic fp16_is_zero(input logic [FP16_WIDTH-1:0] x);
      return (x[FP16_WIDTH-2:0] == '0);
   endfunction

   // Ties, including +0 against -0, go to the first operand.
   function automatic logic [FP16_WIDTH-1:0] fp16_max(input logic [FP16_WIDTH-1:0] a,
                                                      input logic [FP16_WIDTH-1:0] b);
      if (fp16_is_zero(a) && fp16_is_zero(b)) begin
         return a;
      end
      return (fp16_key(b) > fp16_key(a)) ? b : a;
   endfunction

endpackage

// File: rtl/fp16_max2.sv
// Combinational two-input fp16 max; operand a wins ties.
module fp16_max2
   import cnn_pkg::*;
(
   input  logic [FP16_WIDTH-1:0] a,
   input  logic [FP16_WIDTH-1:0] b,
   output logic [FP16_WIDTH-1:0] y
);

   assign y = fp16_max(a, b);

endmodule

// File: rtl/pool_col_streamer.sv
// 2x2 fp16 max-pool streamer: pairs of full-height columns in, one half-height column out.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   HOLDOFF | post-reset kernel-load window, input not accepted
//   EVEN    | waiting for first column of a pair, result goes to hold_q
//   ODD     | waiting for second column, pooled result goes to output
module pool_col_streamer
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH        = FP16_WIDTH,
   parameter int NUM_CHANNELS      = 8,
   parameter int IN_COL_SIZE       = 10,
   parameter int IN_COLS_PER_FRAME = 10,
   parameter int HOLDOFF_CYCLES    = 5
) (
   input  logic                                                      clk,
   input  logic                                                      rst_n,
   input  logic                                                      clear,
   input  logic                                                      valid_in,
   input  logic [NUM_CHANNELS-1:0][IN_COL_SIZE-1:0][DATA_WIDTH-1:0]  in_columns,
   output logic                                                      in_ready,
   output logic                                                      valid_out,
   output logic [NUM_CHANNELS-1:0][IN_COL_SIZE/2-1:0][DATA_WIDTH-1:0] out_columns,
   output logic                                                      frame_done,
   output logic                                                      drop_err
);

   localparam int OUT_ROWS = IN_COL_SIZE / 2;
   localparam int CNT_W    = (IN_COLS_PER_FRAME > 1) ? $clog2(IN_COLS_PER_FRAME) : 1;
   localparam int HOLD_W   = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

   if (IN_COL_SIZE % 2 != 0) begin : g_chk_rows
      $error("pool_col_streamer: IN_COL_SIZE must be even");
   end
   if (IN_COLS_PER_FRAME % 2 != 0) begin : g_chk_cols
      $error("pool_col_streamer: IN_COLS_PER_FRAME must be even");
   end
   if (DATA_WIDTH != FP16_WIDTH) begin : g_chk_width
      $error("pool_col_streamer: DATA_WIDTH must be 16 (fp16)");
   end
   if (HOLDOFF_CYCLES < 1) begin : g_chk_hold
      $error("pool_col_streamer: HOLDOFF_CYCLES must be at least 1");
   end

   pool_state_e                                       state;
   pool_state_e                                       state_nxt;
   logic [HOLD_W-1:0]                                 hold_tmr;
   logic                                              hold_tc;
   logic [CNT_W-1:0]                                  col_cnt;
   logic                                              col_last;
   logic                                              acc_even;
   logic                                              acc_odd;
   logic [NUM_CHANNELS-1:0][OUT_ROWS-1:0][DATA_WIDTH-1:0] vert;
   logic [NUM_CHANNELS-1:0][OUT_ROWS-1:0][DATA_WIDTH-1:0] pool;
   logic [NUM_CHANNELS-1:0][OUT_ROWS-1:0][DATA_WIDTH-1:0] hold_q;

   assign hold_tc  = (hold_tmr == '0);
   assign col_last = (col_cnt == CNT_W'(IN_COLS_PER_FRAME - 1));

   // Vertical max of each row pair, then horizontal max against the held first column.
   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      for (genvar r = 0; r < OUT_ROWS; r++) begin : g_row
         fp16_max2 u_vert (
            .a (in_columns[c][2*r]),
            .b (in_columns[c][2*r+1]),
            .y (vert[c][r])
         );
         fp16_max2 u_horz (
            .a (hold_q[c][r]),
            .b (vert[c][r]),
            .y (pool[c][r])
         );
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= HOLDOFF;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         HOLDOFF: if (hold_tc) state_nxt = EVEN;
         EVEN: begin
            if (clear)         state_nxt = EVEN;
            else if (valid_in) state_nxt = ODD;
         end
         ODD: begin
            if (clear)         state_nxt = EVEN;
            else if (valid_in) state_nxt = EVEN;
         end
         default: state_nxt = HOLDOFF;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      acc_even = 1'b0;
      acc_odd  = 1'b0;
      case (state)
         EVEN: begin
            in_ready = 1'b1;
            acc_even = valid_in && !clear;
         end
         ODD: begin
            in_ready = 1'b1;
            acc_odd  = valid_in && !clear;
         end
         default: ;
      endcase
   end

   // Holdoff down-counter; the window ends on its terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_tmr <= HOLD_W'(HOLDOFF_CYCLES - 1);
      end else if (state == HOLDOFF && !hold_tc) begin
         hold_tmr <= hold_tmr - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt <= '0;
      end else if (clear) begin
         col_cnt <= '0;
      end else if (acc_even || acc_odd) begin
         col_cnt <= col_last ? '0 : col_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
      end else if (clear) begin
         hold_q <= '0;
      end else if (acc_even) begin
         hold_q <= vert;
      end
   end

   // out_columns is not touched by clear so an in-flight result stays valid downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_columns <= '0;
         valid_out   <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         valid_out  <= acc_odd;
         frame_done <= acc_odd && col_last;
         if (acc_odd) begin
            out_columns <= pool;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_err <= 1'b0;
      end else if (clear) begin
         drop_err <= 1'b0;
      end else if (valid_in && !in_ready) begin
         drop_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pool_col_streamer.sv
// Randomized and directed bench for pool_col_streamer against a pair-queue reference model.
module tb_pool_col_streamer;

   localparam int NCH   = 8;
   localparam int ROWS  = 10;
   localparam int HALF  = ROWS / 2;
   localparam int COLS  = 10;
   localparam int HOLD  = 5;
   localparam int DW    = 16;
   localparam int OUT_W = NCH * HALF * DW;

   typedef logic [NCH-1:0][ROWS-1:0][DW-1:0] col_t;
   typedef logic [NCH-1:0][HALF-1:0][DW-1:0] pcol_t;

   logic  clk = 1'b0;
   logic  rst_n;
   logic  clear;
   logic  valid_in;
   col_t  in_columns;
   logic  in_ready;
   logic  valid_out;
   pcol_t out_columns;
   logic  frame_done;
   logic  drop_err;

   pool_col_streamer #(
      .DATA_WIDTH        (DW),
      .NUM_CHANNELS      (NCH),
      .IN_COL_SIZE       (ROWS),
      .IN_COLS_PER_FRAME (COLS),
      .HOLDOFF_CYCLES    (HOLD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .valid_in    (valid_in),
      .in_columns  (in_columns),
      .in_ready    (in_ready),
      .valid_out   (valid_out),
      .out_columns (out_columns),
      .frame_done  (frame_done),
      .drop_err    (drop_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: cycles since reset, the waiting first column of a pair, and frame position.
   int    m_cyc;
   bit    m_have;
   col_t  m_hold;
   int    m_cnt;
   bit    m_drop;
   pcol_t m_out;
   bit    m_vld;
   bit    m_fd;

   logic [DW-1:0] specials [10];

   task automatic chk_eq(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Numeric rank of an fp16 pattern: sign-magnitude, so +0 and -0 rank equal.
   function automatic int fp_rank(input logic [DW-1:0] x);
      int m;
      m = int'(x[DW-2:0]);
      return x[DW-1] ? -m : m;
   endfunction

   // Scan the four window elements in priority order; only a strictly larger value displaces.
   function automatic pcol_t ref_pool(input col_t a, input col_t b);
      pcol_t         p;
      logic [DW-1:0] cand [4];
      logic [DW-1:0] best;
      for (int c = 0; c < NCH; c++) begin
         for (int r = 0; r < HALF; r++) begin
            cand[0] = a[c][2*r];
            cand[1] = a[c][2*r+1];
            cand[2] = b[c][2*r];
            cand[3] = b[c][2*r+1];
            best = cand[0];
            for (int i = 1; i < 4; i++) begin
               if (fp_rank(cand[i]) > fp_rank(best)) best = cand[i];
            end
            p[c][r] = best;
         end
      end
      return p;
   endfunction

   function automatic col_t rand_col();
      col_t col;
      for (int c = 0; c < NCH; c++) begin
         for (int r = 0; r < ROWS; r++) begin
            if ($urandom_range(0, 1) == 0) col[c][r] = specials[$urandom_range(0, 9)];
            else                           col[c][r] = 16'($urandom);
         end
      end
      return col;
   endfunction

   function automatic col_t mk_col(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                                   input logic [DW-1:0] fill);
      col_t col;
      for (int c = 0; c < NCH; c++) begin
         for (int r = 0; r < ROWS; r++) col[c][r] = fill;
      end
      col[0][0] = v0;
      col[0][1] = v1;
      return col;
   endfunction

   function automatic pcol_t fill_pcol(input logic [DW-1:0] v);
      pcol_t p;
      for (int c = 0; c < NCH; c++) begin
         for (int r = 0; r < HALF; r++) p[c][r] = v;
      end
      return p;
   endfunction

   task automatic model_reset();
      m_cyc  = 0;
      m_have = 0;
      m_hold = '0;
      m_cnt  = 0;
      m_drop = 0;
      m_out  = '0;
      m_vld  = 0;
      m_fd   = 0;
   endtask

   // One clock: drive, check in_ready, advance the model, then check registered outputs.
   task automatic cyc(input logic v, input logic c, input col_t col);
      valid_in   = v;
      clear      = c;
      in_columns = col;
      #1;
      chk_eq("in_ready", in_ready, (m_cyc >= HOLD));
      m_vld = 0;
      m_fd  = 0;
      if (c) begin
         m_have = 0;
         m_cnt  = 0;
         m_drop = 0;
      end else if (v && m_cyc < HOLD) begin
         m_drop = 1;
      end else if (v) begin
         m_cnt++;
         if (m_have) begin
            m_out  = ref_pool(m_hold, col);
            m_vld  = 1;
            m_fd   = (m_cnt == COLS);
            m_have = 0;
         end else begin
            m_hold = col;
            m_have = 1;
         end
         if (m_cnt == COLS) m_cnt = 0;
      end
      if (m_cyc < HOLD) m_cyc++;
      @(posedge clk);
      #1;
      chk_eq("valid_out", valid_out, m_vld);
      chk_eq("frame_done", frame_done, m_fd);
      chk_eq("drop_err", drop_err, m_drop);
      chk_eq("out_columns", out_columns, m_out);
   endtask

   initial begin
      int vld_n, fd_n, fd_at;
      specials = '{16'h0000, 16'h8000, 16'h3C00, 16'hBC00, 16'h7C00,
                   16'hFC00, 16'h7E00, 16'hFE00, 16'h0001, 16'h8001};
      rst_n      = 1'b0;
      clear      = 1'b0;
      valid_in   = 1'b0;
      in_columns = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_eq("rst_in_ready", in_ready, 0);
      chk_eq("rst_valid_out", valid_out, 0);
      chk_eq("rst_frame_done", frame_done, 0);
      chk_eq("rst_drop_err", drop_err, 0);
      chk_eq("rst_out_columns", out_columns, 0);
      rst_n = 1'b1;

      // Holdoff with valid_in held high
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, rand_col());
      chk_eq("holdoff_drop", drop_err, 1);
      cyc(1'b0, 1'b1, '0);

      // Basic pool
      cyc(1'b1, 1'b0, mk_col(16'h3C00, 16'h4000, 16'h0000));
      cyc(1'b1, 1'b0, mk_col(16'h3800, 16'hBC00, 16'h0000));
      chk_eq("basic_valid", valid_out, 1);
      chk_eq("basic_max", out_columns[0][0], 16'h4000);

      // Negatives and signed zeros
      cyc(1'b1, 1'b0, mk_col(16'hC000, 16'hBC00, 16'h0000));
      cyc(1'b1, 1'b0, mk_col(16'hC000, 16'hC000, 16'h0000));
      chk_eq("neg_max", out_columns[0][0], 16'hBC00);
      cyc(1'b1, 1'b0, mk_col(16'h0000, 16'h8000, 16'h8000));
      cyc(1'b1, 1'b0, mk_col(16'h8000, 16'h8000, 16'h8000));
      chk_eq("pos_zero_first", out_columns[0][0], 16'h0000);
      cyc(1'b1, 1'b0, mk_col(16'h8000, 16'h0000, 16'h0000));
      cyc(1'b1, 1'b0, mk_col(16'h0000, 16'h0000, 16'h0000));
      chk_eq("neg_zero_first", out_columns[0][0], 16'h8000);

      // Full frame back to back, then the next frame starts on an even column
      cyc(1'b0, 1'b1, '0);
      vld_n = 0;
      fd_n  = 0;
      fd_at = 0;
      for (int i = 0; i < COLS; i++) begin
         cyc(1'b1, 1'b0, rand_col());
         if (valid_out) vld_n++;
         if (frame_done) begin
            fd_n++;
            fd_at = vld_n;
         end
      end
      chk_eq("frame_pulses", vld_n, 5);
      chk_eq("frame_done_count", fd_n, 1);
      chk_eq("frame_done_position", fd_at, 5);
      cyc(1'b1, 1'b0, rand_col());
      chk_eq("next_frame_even", valid_out, 0);
      cyc(1'b1, 1'b0, rand_col());
      chk_eq("next_frame_pair", valid_out, 1);

      // Clear between the two columns of a pair
      cyc(1'b0, 1'b1, '0);
      cyc(1'b1, 1'b0, mk_col(16'h4000, 16'h4000, 16'h4000));
      cyc(1'b1, 1'b1, mk_col(16'h4000, 16'h4000, 16'h4000));
      chk_eq("clear_drop_err", drop_err, 0);
      cyc(1'b1, 1'b0, mk_col(16'h3C00, 16'h3C00, 16'h3C00));
      chk_eq("clear_restart_even", valid_out, 0);
      cyc(1'b1, 1'b0, mk_col(16'h3C00, 16'h3C00, 16'h3C00));
      chk_eq("clear_no_leak", out_columns, fill_pcol(16'h3C00));

      // Random traffic with occasional clears
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 29) == 0), rand_col());
      end

      // Asynchronous reset after three accepted columns
      cyc(1'b0, 1'b1, '0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, rand_col());
      #2;
      rst_n = 1'b0;
      #1;
      chk_eq("arst_in_ready", in_ready, 0);
      chk_eq("arst_valid_out", valid_out, 0);
      chk_eq("arst_frame_done", frame_done, 0);
      chk_eq("arst_drop_err", drop_err, 0);
      chk_eq("arst_out_columns", out_columns, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1'b1, 1'b1, rand_col());
      chk_eq("holdoff_clear_wins", drop_err, 0);
      for (int i = 1; i < 8; i++) cyc(1'b1, 1'b0, rand_col());
      chk_eq("holdoff2_drop", drop_err, 1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
